// File: rtl/pcm_frame_assembler_if.sv
// Byte-in / sample-out bundle for the PCM frame assembler: UART receive side,
// FIFO write side, flow control, and status/error counters.
interface pcm_frame_assembler_if #(
  parameter int unsigned FILL_BITS = 13
);
  logic [7:0]           rx_data;
  logic                 received;
  logic [FILL_BITS-1:0] fifo_fill;
  logic                 fifo_full;
  logic                 wr_en;
  logic [15:0]          wr_data;
  logic                 cts;
  logic                 in_packet;
  logic                 frame_ok;
  logic [7:0]           csum_errs;
  logic [7:0]           timeout_errs;
  logic [7:0]           overflow_drops;

  // Assembler side
  modport slave (
    input  rx_data, received, fifo_fill, fifo_full,
    output wr_en, wr_data, cts, in_packet, frame_ok,
           csum_errs, timeout_errs, overflow_drops
  );

  // Byte source / sample sink side
  modport master (
    output rx_data, received, fifo_fill, fifo_full,
    input  wr_en, wr_data, cts, in_packet, frame_ok,
           csum_errs, timeout_errs, overflow_drops
  );
endinterface

// File: rtl/pcm_frame_assembler.sv
// Framed PCM receive stage: hunts for a sync byte, parses a length-prefixed
// packet of stereo 8-bit pairs, writes each pair to the sample FIFO as it
// completes, checks a trailing modulo-256 checksum, aborts on inter-byte
// timeout, drives host CTS from FIFO fill with hysteresis, and keeps
// saturating error counters.
module pcm_frame_assembler #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned FILL_BITS      = 13,
  parameter int unsigned LOW_MARK       = 2457,
  parameter int unsigned HIGH_MARK      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 400
) (
  input logic                  clk,
  input logic                  reset,
  pcm_frame_assembler_if.slave bus
);

  localparam int unsigned          IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FILL_BITS-1:0] LOW_FILL  = FILL_BITS'(LOW_MARK);
  localparam logic [FILL_BITS-1:0] HIGH_FILL = FILL_BITS'(HIGH_MARK);

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_RIGHT,
    ST_LEFT,
    ST_CSUM
  } state_t;

  state_t            state_q;
  logic [7:0]        sum_q;
  logic [7:0]        pairs_q;
  logic [7:0]        right_q;
  logic [IDLE_W-1:0] idle_q;
  logic              wr_en_q;
  logic [15:0]       wr_data_q;
  logic              frame_ok_q;
  logic              cts_q;
  logic [7:0]        csum_errs_q;
  logic [7:0]        timeout_errs_q;
  logic [7:0]        overflow_drops_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Packet parser: byte-driven state walk, FIFO write, checksum and idle timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_HUNT;
      sum_q            <= '0;
      pairs_q          <= '0;
      right_q          <= '0;
      idle_q           <= '0;
      wr_en_q          <= 1'b0;
      wr_data_q        <= '0;
      frame_ok_q       <= 1'b0;
      csum_errs_q      <= '0;
      timeout_errs_q   <= '0;
      overflow_drops_q <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      frame_ok_q <= 1'b0;
      if (bus.received) begin
        // A byte arriving on the expiry cycle is processed; no timeout fires.
        idle_q <= '0;
        unique case (state_q)
          ST_HUNT: begin
            if (bus.rx_data == SYNC_BYTE) state_q <= ST_LEN;
          end
          ST_LEN: begin
            if (bus.rx_data == 8'd0) begin
              state_q        <= ST_HUNT;
              timeout_errs_q <= sat_inc(timeout_errs_q);
            end else begin
              pairs_q <= bus.rx_data;
              sum_q   <= bus.rx_data;
              state_q <= ST_RIGHT;
            end
          end
          ST_RIGHT: begin
            right_q <= bus.rx_data;
            sum_q   <= sum_q + bus.rx_data;
            state_q <= ST_LEFT;
          end
          ST_LEFT: begin
            sum_q <= sum_q + bus.rx_data;
            if (!bus.fifo_full) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= {bus.rx_data, right_q};
            end else begin
              overflow_drops_q <= sat_inc(overflow_drops_q);
            end
            pairs_q <= pairs_q - 8'd1;
            state_q <= (pairs_q == 8'd1) ? ST_CSUM : ST_RIGHT;
          end
          ST_CSUM: begin
            if (bus.rx_data == sum_q) frame_ok_q  <= 1'b1;
            else                      csum_errs_q <= sat_inc(csum_errs_q);
            state_q <= ST_HUNT;
          end
          default: state_q <= ST_HUNT;
        endcase
      end else if (state_q != ST_HUNT) begin
        if (idle_q == IDLE_LAST) begin
          state_q        <= ST_HUNT;
          timeout_errs_q <= sat_inc(timeout_errs_q);
          idle_q         <= '0;
        end else begin
          idle_q <= idle_q + 1'b1;
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

  // Host flow control: hysteresis between the low and high fill marks
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_q <= 1'b0;
    end else if (bus.fifo_fill <= LOW_FILL) begin
      cts_q <= 1'b1;
    end else if (bus.fifo_fill >= HIGH_FILL) begin
      cts_q <= 1'b0;
    end
  end

  assign bus.wr_en          = wr_en_q;
  assign bus.wr_data        = wr_data_q;
  assign bus.frame_ok       = frame_ok_q;
  assign bus.cts            = cts_q;
  assign bus.in_packet      = (state_q != ST_HUNT);
  assign bus.csum_errs      = csum_errs_q;
  assign bus.timeout_errs   = timeout_errs_q;
  assign bus.overflow_drops = overflow_drops_q;

endmodule
